// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4-row x 3-column matrix keypad for a tic-tac-toe game. Keys 1..9
// select board cells, and keys 10..12 (*, 0, #) are control keys. One row is
// driven low at a time. The row changes once per scan tick, and the column
// lines are sampled on the same tick. A key is accepted only after it reads
// identically on DEBOUNCE_SCANS consecutive ticks. It is then reported once,
// and the scanner waits for a full release before it looks for another key.
//
// Cell keys that land on an occupied board cell are reported as a reject
// instead of a valid key.
//
// Parameters
//   SCAN_DIV        clk cycles per scan tick
//   DEBOUNCE_SCANS  consecutive identical tick samples to accept press/release
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   enable      high while a game is in progress
//   board[17:0] occupancy; cell k: O at bit 19-2k, X at bit 18-2k
//   key_col     column sense lines, active low (pulled up externally)
//   key_row     row drive, one-hot active low
//   key_data    accepted key code during the emit cycle, 0 otherwise
//   key_valid   one-cycle strobe: key accepted
//   key_reject  one-cycle strobe: cell key on an occupied cell
//   key_held    high while an accepted key is still down
//
// key_col is only looked at on tick cycles, long after the row drive settles.
// If the column lines come straight from pins, put a synchronizer in front of
// this block.
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [17:0] board,
    input  logic [2:0]  key_col,
    output logic [3:0]  key_row,
    output logic [3:0]  key_data,
    output logic        key_valid,
    output logic        key_reject,
    output logic        key_held
);

    localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic [1:0]          row_idx;
    logic [1:0]          row_idx_next;
    logic [1:0]          cand_col;
    logic [1:0]          cand_col_next;
    logic [CNT_W-1:0]    deb_cnt;
    logic [CNT_W-1:0]    deb_cnt_next;
    logic [CNT_W-1:0]    rel_cnt;
    logic [CNT_W-1:0]    rel_cnt_next;
    logic [CNT_W-1:0]    deb_inc;
    logic [CNT_W-1:0]    rel_inc;

    logic                single_low;
    logic [1:0]          col_idx;
    logic [3:0]          code;
    logic [8:0]          cell_occ;
    logic                occupied;
    logic                emit_ok;

    // Free-running scan divider. It keeps counting while the game is
    // disabled, so the row rotation never stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // A usable sample has exactly one column low. Anything else (no key, or
    // several keys on the driven row) counts as "no candidate".
    always_comb begin
        single_low = 1'b0;
        col_idx    = 2'd0;
        case (key_col)
            3'b110: begin single_low = 1'b1; col_idx = 2'd0; end
            3'b101: begin single_low = 1'b1; col_idx = 2'd1; end
            3'b011: begin single_low = 1'b1; col_idx = 2'd2; end
            default: begin single_low = 1'b0; col_idx = 2'd0; end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= SCAN;
            row_idx  <= 2'd0;
            cand_col <= 2'd0;
            deb_cnt  <= '0;
            rel_cnt  <= '0;
        end else begin
            state    <= state_next;
            row_idx  <= row_idx_next;
            cand_col <= cand_col_next;
            deb_cnt  <= deb_cnt_next;
            rel_cnt  <= rel_cnt_next;
        end
    end

    assign deb_inc = deb_cnt + CNT_W'(1);
    assign rel_inc = rel_cnt + CNT_W'(1);

    // The row index freezes while a candidate is being confirmed or held.
    // Row rotation happens only on ticks. A disabled game drops any
    // candidate at once, but the rows keep rotating.
    always_comb begin
        state_next    = state;
        row_idx_next  = row_idx;
        cand_col_next = cand_col;
        deb_cnt_next  = deb_cnt;
        rel_cnt_next  = rel_cnt;

        if (!enable) begin
            state_next   = SCAN;
            deb_cnt_next = '0;
            rel_cnt_next = '0;
            if (tick) begin
                row_idx_next = row_idx + 2'd1;
            end
        end else begin
            case (state)
                SCAN: begin
                    if (tick) begin
                        if (single_low) begin
                            cand_col_next = col_idx;
                            deb_cnt_next  = CNT_W'(1);
                            state_next    = (DEBOUNCE_SCANS <= 1) ? EMIT : DEBOUNCE;
                        end else begin
                            row_idx_next = row_idx + 2'd1;
                        end
                    end
                end

                DEBOUNCE: begin
                    if (tick) begin
                        if (single_low && (col_idx == cand_col)) begin
                            deb_cnt_next = deb_inc;
                            if (deb_inc == CNT_TARGET) begin
                                state_next = EMIT;
                            end
                        end else begin
                            deb_cnt_next = '0;
                            row_idx_next = row_idx + 2'd1;
                            state_next   = SCAN;
                        end
                    end
                end

                EMIT: begin
                    deb_cnt_next = '0;
                    rel_cnt_next = '0;
                    state_next   = HOLD;
                end

                HOLD: begin
                    // Any low column, even from another key, restarts the
                    // release count. A second key cannot emit until everything
                    // is released.
                    if (tick) begin
                        if (key_col == 3'b111) begin
                            if (rel_inc == CNT_TARGET) begin
                                rel_cnt_next = '0;
                                row_idx_next = row_idx + 2'd1;
                                state_next   = SCAN;
                            end else begin
                                rel_cnt_next = rel_inc;
                            end
                        end else begin
                            rel_cnt_next = '0;
                        end
                    end
                end

                default: begin
                    state_next = SCAN;
                end
            endcase
        end
    end

    // Key code of the frozen candidate: row-major, 1..12.
    assign code = (4'(row_idx) * 4'd3) + 4'(cand_col) + 4'd1;

    // Cell k uses the 2-bit group at bits [19-2k:18-2k], which is group 9-k.
    always_comb begin
        cell_occ = '0;
        for (int k = 1; k <= 9; k++) begin
            cell_occ[k-1] = |board[2*(9-k) +: 2];
        end
    end

    // The strobes decode straight from the registered state. This way the
    // board is looked at only during the single EMIT cycle, and key_data
    // drops back to 0 on the next cycle.
    always_comb begin
        occupied = 1'b0;
        if (code <= 4'd9) begin
            occupied = cell_occ[code - 4'd1];
        end
    end

    assign emit_ok    = (state == EMIT) && enable;
    assign key_valid  = emit_ok && !occupied;
    assign key_reject = emit_ok && occupied;
    assign key_data   = key_valid ? code : 4'd0;
    assign key_held   = (state == HOLD);

    always_comb begin
        key_row          = 4'b1111;
        key_row[row_idx] = 1'b0;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// This bench drives keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3) through a
// modelled key matrix. Each pressed key pulls its column low while its row is
// driven low.
//
// A behavioural model follows the scanner tick by tick, in terms of the
// keypad: which row is driven, whether a key is being confirmed or held, and
// how many stable samples have been seen. Every cycle, the DUT outputs are
// compared with this model. Each scenario also checks hand-computed counts of
// strobes and codes.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        enable = 1'b0;
    logic [17:0] board  = '0;
    logic [11:0] pressed = '0;
    logic [2:0]  key_col;
    logic [3:0]  key_row;
    logic [3:0]  key_data;
    logic        key_valid;
    logic        key_reject;
    logic        key_held;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .board      (board),
        .key_col    (key_col),
        .key_row    (key_row),
        .key_data   (key_data),
        .key_valid  (key_valid),
        .key_reject (key_reject),
        .key_held   (key_held)
    );

    // The key matrix: a pressed key shorts its column to its row.
    always_comb begin
        key_col = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (key_row[r] == 1'b0 && pressed[r*3+c]) begin
                    key_col[c] = 1'b0;
                end
            end
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_cnt     = 0;
    int         m_row     = 0;
    bit         m_locked  = 0;
    bit         m_holding = 0;
    bit         m_emit    = 0;
    int         m_streak  = 0;
    int         m_rel     = 0;
    int         m_code    = 0;
    logic [2:0] m_pat     = 3'b111;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0; m_row = 0; m_locked = 0; m_holding = 0;
            m_emit = 0; m_streak = 0; m_rel = 0; m_code = 0; m_pat = 3'b111;
        end else begin
            bit tick_now;
            bit emit_now;
            int lows;
            int col;
            tick_now = (m_cnt == SCAN_DIV - 1);
            m_cnt    = (m_cnt + 1) % SCAN_DIV;
            emit_now = 0;
            lows = 0;
            col  = 0;
            for (int c = 0; c < 3; c++) begin
                if (!key_col[c]) begin
                    lows++;
                    col = c;
                end
            end
            if (!enable) begin
                m_locked = 0; m_holding = 0; m_streak = 0; m_rel = 0;
                if (tick_now) m_row = (m_row + 1) % 4;
            end else if (m_emit) begin
                m_holding = 1;
                m_rel     = 0;
            end else if (tick_now) begin
                if (m_holding) begin
                    if (key_col == 3'b111) m_rel++;
                    else m_rel = 0;
                    if (m_rel == DEB) begin
                        m_holding = 0;
                        m_rel     = 0;
                        m_row     = (m_row + 1) % 4;
                    end
                end else if (m_locked) begin
                    if (lows == 1 && key_col == m_pat) begin
                        m_streak++;
                        if (m_streak == DEB) begin
                            m_locked = 0;
                            emit_now = 1;
                        end
                    end else begin
                        m_locked = 0;
                        m_streak = 0;
                        m_row    = (m_row + 1) % 4;
                    end
                end else if (lows == 1) begin
                    m_locked = 1;
                    m_streak = 1;
                    m_pat    = key_col;
                    m_code   = m_row * 3 + col + 1;
                end else begin
                    m_row = (m_row + 1) % 4;
                end
            end
            m_emit = emit_now;
        end
    end

    // Per-cycle comparison against the model, plus cumulative strobe counts.
    int valid_cnt  = 0;
    int reject_cnt = 0;
    int rise_cnt   = 0;
    int last_code  = 0;
    logic [3:0] prev_data = 4'd0;

    always @(negedge clk) begin
        logic [3:0] e_row;
        bit occ;
        bit e_valid;
        bit e_reject;
        e_row = 4'b1111;
        e_row[m_row] = 1'b0;
        occ = 0;
        if (m_code >= 1 && m_code <= 9) occ = board[19-2*m_code] | board[18-2*m_code];
        e_valid  = m_emit && enable && !occ;
        e_reject = m_emit && enable && occ;
        check_output("key_row", key_row, e_row);
        check_output("key_valid", key_valid, e_valid);
        check_output("key_reject", key_reject, e_reject);
        check_output("key_data", key_data, e_valid ? m_code : 0);
        check_output("key_held", key_held, m_holding);
        check_output("valid_reject_exclusive", key_valid & key_reject, 0);
        if (key_valid) begin
            valid_cnt++;
            last_code = key_data;
        end
        if (key_reject) reject_cnt++;
        if (prev_data == 4'd0 && key_data != 4'd0) rise_cnt++;
        prev_data = key_data;
    end

    // ---------------- stimulus ----------------
    int base_valid, base_reject, base_rise;

    function automatic logic [11:0] key_mask(input int code);
        logic [11:0] one;
        one = 12'd1;
        return one << (code - 1);
    endfunction

    task automatic apply_stimulus(input logic [11:0] keys, input int ticks);
        pressed = keys;
        repeat (ticks * SCAN_DIV) @(posedge clk);
        #2;
    endtask

    task automatic mark();
        base_valid  = valid_cnt;
        base_reject = reject_cnt;
        base_rise   = rise_cnt;
    endtask

    task automatic check_counts(input string name, input int ev, input int er, input int ecode);
        check_output({name, "_valid_cnt"}, valid_cnt - base_valid, ev);
        check_output({name, "_reject_cnt"}, reject_cnt - base_reject, er);
        check_output({name, "_data_rises"}, rise_cnt - base_rise, ev);
        if (ev > 0) check_output({name, "_code"}, last_code, ecode);
    endtask

    initial begin
        int waited;
        repeat (3) @(posedge clk);
        #2;
        check_output("reset_key_row", key_row, 4'b1110);
        check_output("reset_key_data", key_data, 0);
        check_output("reset_strobes", {key_valid, key_reject, key_held}, 0);
        rst    = 1'b1;
        enable = 1'b1;

        // Key 5 held for a long time: one accept, held until released.
        mark();
        apply_stimulus(key_mask(5), 40);
        check_output("k5_held_while_down", key_held, 1);
        check_output("k5_data_back_to_0", key_data, 0);
        apply_stimulus('0, 10);
        check_output("k5_held_after_release", key_held, 0);
        check_counts("k5", 1, 0, 5);

        // Cell 5 already taken by O: reject only.
        board = 18'h00200;
        mark();
        apply_stimulus(key_mask(5), 20);
        apply_stimulus('0, 10);
        check_counts("k5_occupied", 0, 1, 0);
        board = '0;

        // Key 1 bouncing on alternate ticks, then stable.
        mark();
        for (int i = 0; i < 10; i++) begin
            apply_stimulus((i % 2 == 0) ? key_mask(1) : 12'd0, 1);
        end
        check_counts("k1_bounce", 0, 0, 0);
        apply_stimulus(key_mask(1), 12);
        apply_stimulus('0, 10);
        check_counts("k1_stable", 1, 0, 1);

        // Keys 4 and 6 together: two low columns, never accepted.
        mark();
        apply_stimulus(key_mask(4) | key_mask(6), 20);
        apply_stimulus('0, 10);
        check_counts("k4_k6", 0, 0, 0);

        // 9 held, then 7 added: no second emission until full release.
        mark();
        apply_stimulus(key_mask(9), 20);
        check_output("k9_held", key_held, 1);
        apply_stimulus(key_mask(9) | key_mask(7), 20);
        apply_stimulus(key_mask(7), 10);
        check_output("k7_still_held", key_held, 1);
        apply_stimulus('0, 10);
        check_output("k9_k7_released", key_held, 0);
        check_counts("k9_then_k7", 1, 0, 9);

        // '#' ignores a full board; nothing at all while disabled.
        board = 18'h3FFFF;
        mark();
        apply_stimulus(key_mask(12), 20);
        apply_stimulus('0, 10);
        check_counts("hash_full_board", 1, 0, 12);
        enable = 1'b0;
        mark();
        apply_stimulus(key_mask(12), 20);
        check_output("hash_disabled_held", key_held, 0);
        apply_stimulus('0, 10);
        check_counts("hash_disabled", 0, 0, 0);
        enable = 1'b1;
        board  = '0;

        // Reset while key 3 is being confirmed.
        mark();
        pressed = key_mask(3);
        waited  = 0;
        while (!m_locked && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check_output("k3_reached_debounce", m_locked, 1);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_mid_key_row", key_row, 4'b1110);
        check_output("rst_mid_key_data", key_data, 0);
        check_output("rst_mid_strobes", {key_valid, key_reject, key_held}, 0);
        pressed = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_release_key_row", key_row, 4'b1110);
        @(posedge clk);
        #2;
        apply_stimulus('0, 10);
        check_counts("k3_reset", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
